// File: rtl/dff_force_ctrl.sv
// Force controller for a bank of N set/reset flops: grants one of two requesters,
// pulses s or r for HOLD cycles, waits GAP cycles, then checks the read-back q.
module dff_force_ctrl #(
  parameter int N    = 8,
  parameter int HOLD = 3,
  parameter int GAP  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic         op0,
  input  logic         op1,
  input  logic [N-1:0] mask0,
  input  logic [N-1:0] mask1,
  input  logic [N-1:0] q,
  output logic [N-1:0] s,
  output logic [N-1:0] r,
  output logic         ack0,
  output logic         ack1,
  output logic         err,
  output logic         busy
);

  typedef enum logic [2:0] {IDLE, FORCE, RELEASE, CHECK, DONE} state_t;

  localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);
  localparam logic [3:0] GAP_M1  = 4'(GAP - 1);

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         rr_q, rr_d;
  logic         gnt_q, gnt_d;
  logic         op_q, op_d;
  logic [N-1:0] mask_q, mask_d;
  logic [N-1:0] s_q, s_d, r_q, r_d;
  logic         ack0_q, ack0_d, ack1_q, ack1_d;
  logic         err_q, err_d, busy_q, busy_d;
  logic         sel;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    mask_d  = mask_q;
    err_d   = 1'b0;
    sel     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // rr_q names the requester that wins a tie
          sel    = (req0 && req1) ? rr_q : req1;
          gnt_d  = sel;
          rr_d   = ~sel;
          op_d   = sel ? op1 : op0;
          mask_d = sel ? mask1 : mask0;
          if (mask_d == '0) begin
            state_d = DONE;
          end else begin
            state_d = FORCE;
            cnt_d   = HOLD_M1;
          end
        end
      end
      FORCE: begin
        if (cnt_q == 4'd0) begin
          state_d = RELEASE;
          cnt_d   = GAP_M1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RELEASE: begin
        if (cnt_q == 4'd0) state_d = CHECK;
        else               cnt_d   = cnt_q - 4'd1;
      end
      CHECK: begin
        state_d = DONE;
        err_d   = |((q ^ {N{op_q}}) & mask_q);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from the next state so they come straight off flops
  always_comb begin
    s_d    = (state_d == FORCE &&  op_d) ? mask_d : '0;
    r_d    = (state_d == FORCE && !op_d) ? mask_d : '0;
    ack0_d = (state_d == DONE) && !gnt_d;
    ack1_d = (state_d == DONE) &&  gnt_d;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rr_q    <= 1'b0;
      s_q     <= '0;
      r_q     <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      s_q     <= s_d;
      r_q     <= r_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Latched transaction data; only meaningful while busy, so left unreset
  always_ff @(posedge clk) begin
    gnt_q  <= gnt_d;
    op_q   <= op_d;
    mask_q <= mask_d;
  end

  assign s    = s_q;
  assign r    = r_q;
  assign ack0 = ack0_q;
  assign ack1 = ack1_q;
  assign err  = err_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_dff_force_ctrl.sv
// Directed bench for dff_force_ctrl with a behavioural set/reset flop bank on q.
module tb_dff_force_ctrl;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
  logic [N-1:0] mask0 = '0, mask1 = '0;
  logic [N-1:0] q, s, r;
  logic         ack0, ack1, err, busy;
  logic         stuck_en = 1'b0;
  logic [N-1:0] stuck_val = '0;
  logic [N-1:0] ff_q;
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) ff_q <= '0;
    else        ff_q <= (ff_q | s) & ~r;

  assign q = stuck_en ? stuck_val : ff_q;

  dff_force_ctrl #(.N(N), .HOLD(3), .GAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .mask0(mask0), .mask1(mask1), .q(q), .s(s), .r(r),
    .ack0(ack0), .ack1(ack1), .err(err), .busy(busy)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ((s & r) !== '0) begin
        failures++;
        $display("FAIL s_r_overlap: s=%h r=%h required s&r=0", s, r);
      end
      checks++;
      if (ack0 && ack1) begin
        failures++;
        $display("FAIL both_acks: ack0=%b ack1=%b required not both", ack0, ack1);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({s, r, ack0, ack1, err, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: s=%h r=%h ack0=%b ack1=%b err=%b busy=%b required all 0",
               s, r, ack0, ack1, err, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b required 0", busy);
    end
  endtask

  task automatic test_set();
    logic [N-1:0] exp_s;
    stuck_en = 1'b0;
    req0 = 1'b1; op0 = 1'b1; mask0 = 8'h0F;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      exp_s = (c <= 3) ? 8'h0F : 8'h00;
      checks++;
      if (s !== exp_s) begin
        failures++;
        $display("FAIL set_s_c%0d: s=%h required %h", c, s, exp_s);
      end
      checks++;
      if (r !== 8'h00) begin
        failures++;
        $display("FAIL set_r_c%0d: r=%h required 00", c, r);
      end
      checks++;
      if (ack0 !== (c == 6)) begin
        failures++;
        $display("FAIL set_ack0_c%0d: ack0=%b required %b", c, ack0, (c == 6));
      end
      checks++;
      if (busy !== (c <= 6)) begin
        failures++;
        $display("FAIL set_busy_c%0d: busy=%b required %b", c, busy, (c <= 6));
      end
      checks++;
      if (err !== 1'b0) begin
        failures++;
        $display("FAIL set_err_c%0d: err=%b required 0", c, err);
      end
      if (c == 1) begin
        mask0 = 8'h33; op0 = 1'b0;
      end
      if (c == 6) req0 = 1'b0;
    end
  endtask

  task automatic test_clear();
    logic [N-1:0] exp_r;
    stuck_en = 1'b1; stuck_val = 8'hFF;
    req1 = 1'b1; op1 = 1'b0; mask1 = 8'hF0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      exp_r = (c <= 3) ? 8'hF0 : 8'h00;
      checks++;
      if (r !== exp_r) begin
        failures++;
        $display("FAIL clr_r_c%0d: r=%h required %h", c, r, exp_r);
      end
      checks++;
      if (s !== 8'h00) begin
        failures++;
        $display("FAIL clr_s_c%0d: s=%h required 00", c, s);
      end
      checks++;
      if ({ack0, ack1} !== {1'b0, (c == 6)}) begin
        failures++;
        $display("FAIL clr_ack_c%0d: ack0=%b ack1=%b required 0 %b", c, ack0, ack1, (c == 6));
      end
      checks++;
      if (err !== (c == 6)) begin
        failures++;
        $display("FAIL clr_err_c%0d: err=%b required %b", c, err, (c == 6));
      end
      if (c == 6) req1 = 1'b0;
    end
    stuck_en = 1'b0;
  endtask

  task automatic test_round_robin();
    int exp_g[3] = '{0, 1, 0};
    int got;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req0 = 1'b1; op0 = 1'b1; mask0 = 8'h01;
    req1 = 1'b1; op1 = 1'b1; mask1 = 8'h02;
    for (int t = 0; t < 3; t++) begin
      got = -1;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (ack0 || ack1) begin
          got = ack1 ? 1 : 0;
          break;
        end
      end
      checks++;
      if (got != exp_g[t]) begin
        failures++;
        $display("FAIL rr_grant_%0d: granted=%0d required %0d", t, got, exp_g[t]);
      end
      if (t == 2) begin
        req0 = 1'b0; req1 = 1'b0;
      end else if (got == 1) req1 = 1'b0;
      else                   req0 = 1'b0;
      @(negedge clk);
      checks++;
      if ({ack0, ack1} !== 2'b00) begin
        failures++;
        $display("FAIL rr_ack_pulse_%0d: ack0=%b ack1=%b required 00", t, ack0, ack1);
      end
      if (t < 2) begin
        req0 = 1'b1; req1 = 1'b1;
      end
    end
  endtask

  task automatic test_zero_mask();
    req0 = 1'b1; op0 = 1'b1; mask0 = 8'h00;
    @(negedge clk);
    checks++;
    if ({ack0, ack1, err, s, r} !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00}) begin
      failures++;
      $display("FAIL zero_mask_c1: ack0=%b ack1=%b err=%b s=%h r=%h required 1 0 0 00 00",
               ack0, ack1, err, s, r);
    end
    req0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({ack0, busy, s, r} !== '0) begin
      failures++;
      $display("FAIL zero_mask_c2: ack0=%b busy=%b s=%h r=%h required all 0", ack0, busy, s, r);
    end
  endtask

  task automatic test_reset_abort();
    req0 = 1'b1; op0 = 1'b1; mask0 = 8'h0F;
    @(negedge clk);
    checks++;
    if (s !== 8'h0F) begin
      failures++;
      $display("FAIL abort_force_c1: s=%h required 0f", s);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s, r, busy, ack0, ack1} !== '0) begin
      failures++;
      $display("FAIL abort_async: s=%h r=%h busy=%b ack0=%b ack1=%b required all 0",
               s, r, busy, ack0, ack1);
    end
    req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({ack0, ack1, busy} !== 3'b000) begin
        failures++;
        $display("FAIL abort_no_ack_%0d: ack0=%b ack1=%b busy=%b required 000", c, ack0, ack1, busy);
      end
    end
    req1 = 1'b1; op1 = 1'b1; mask1 = 8'h3C;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++;
      if (ack1 !== (c == 6)) begin
        failures++;
        $display("FAIL after_abort_ack1_c%0d: ack1=%b required %b", c, ack1, (c == 6));
      end
      if (c == 6) begin
        checks++;
        if (err !== 1'b0) begin
          failures++;
          $display("FAIL after_abort_err: err=%b required 0", err);
        end
        req1 = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_set();
    test_clear();
    test_round_robin();
    test_zero_mask();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
